// File: rtl/pattern_tx_if.sv
// Purpose : request/response bundle for the pattern transmitter.
// Ports   : start/pattern/len/abort flow into the transmitter;
//           p1/p2/busy/done flow out of it.
//           master = requester side, slave = transmitter side.
interface pattern_tx_if #(
    parameter int unsigned MAXLEN = 8
);
    localparam int unsigned LEN_W = 4;

    logic              start;
    logic [MAXLEN-1:0] pattern;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              p1;
    logic              p2;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output pattern,
        output len,
        output abort,
        input  p1,
        input  p2,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  pattern,
        input  len,
        input  abort,
        output p1,
        output p2,
        output busy,
        output done
    );
endinterface

// File: rtl/pattern_tx.sv
// Purpose : serial symbol transmitter. Sends len symbols of a latched
//           pattern MSB-first (bit[len-1] first) as one-cycle pulses,
//           p1 for a '1' and p2 for a '0', with GAP idle cycles after
//           each symbol, then a one-cycle done pulse.
// Ports   : clk   - sole clock, rising edge
//           reset - asynchronous, active-low
//           bus   - pattern_tx_if.slave (start, pattern, len, abort in;
//                   p1, p2, busy, done out)
// Outputs are registered and always equal a decode of the registered
// state, so they carry no combinational path from the inputs.
module pattern_tx #(
    parameter int unsigned GAP    = 1,
    parameter int unsigned MAXLEN = 8
) (
    input  logic           clk,
    input  logic           reset,
    pattern_tx_if.slave    bus
);

    localparam int unsigned IDX_W   = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam int unsigned GAP_W   = 4;
    localparam bit          HAS_GAP = (GAP != 0);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [MAXLEN-1:0]  r_pat;
    logic [IDX_W-1:0]   r_idx;
    logic [GAP_W-1:0]   r_gap;
    logic               r_p1;
    logic               r_p2;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [MAXLEN-1:0]  w_pat_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic [IDX_W-1:0]   w_first_idx;
    logic               w_bit_nxt;
    logic               w_p1_nxt;
    logic               w_p2_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // Index of the first symbol; over-long requests are clamped to MAXLEN.
    always_comb begin
        w_first_idx = '0;
        if (32'(bus.len) > MAXLEN) begin
            w_first_idx = IDX_W'(MAXLEN - 1);
        end else begin
            w_first_idx = IDX_W'(bus.len - 4'd1);
        end
    end

    // Next-state logic plus the output decode of the next state.
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = r_gap;

        case (r_state)
            S_IDLE: begin
                if (bus.start && (bus.len != 4'd0)) begin
                    w_state_nxt = S_SEND;
                    w_pat_nxt   = bus.pattern;
                    w_idx_nxt   = w_first_idx;
                    w_gap_nxt   = '0;
                end
            end

            S_SEND: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (HAS_GAP) begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = GAP_LOAD;
                end else if (r_idx == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = r_idx - IDX_W'(1);
                end
            end

            S_GAP: begin
                // abort outranks the final gap expiry, so no done follows
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap == '0) begin
                    if (r_idx == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SEND;
                        w_idx_nxt   = r_idx - IDX_W'(1);
                    end
                end else begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_bit_nxt  = w_pat_nxt[w_idx_nxt];
        w_p1_nxt   = (w_state_nxt == S_SEND) &&  w_bit_nxt;
        w_p2_nxt   = (w_state_nxt == S_SEND) && !w_bit_nxt;
        w_busy_nxt = (w_state_nxt == S_SEND) || (w_state_nxt == S_GAP);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_idx   <= '0;
            r_gap   <= '0;
            r_p1    <= 1'b0;
            r_p2    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_idx   <= w_idx_nxt;
            r_gap   <= w_gap_nxt;
            r_p1    <= w_p1_nxt;
            r_p2    <= w_p2_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.p1   = r_p1;
    assign bus.p2   = r_p2;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: two instances (GAP=1 and GAP=0).
// Stimulus pushes expected {cycle, p1,p2,busy,done, busy-run} records;
// a monitor per instance pops one record for every p1/p2/done pulse.
module tb_pattern_tx;

    localparam int unsigned MAXLEN = 8;
    localparam logic [3:0]  V_P1   = 4'b1010;
    localparam logic [3:0]  V_P2   = 4'b0110;
    localparam logic [3:0]  V_DN   = 4'b0001;
    localparam int          NB_ANY = -1;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
        int         nbusy;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    ev_t  q0[$];
    ev_t  q1[$];
    int   run0 = 0;
    int   run1 = 0;
    ev_t  m0_e;
    ev_t  m1_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pattern_tx_if #(.MAXLEN(MAXLEN)) bus0 ();
    pattern_tx_if #(.MAXLEN(MAXLEN)) bus1 ();

    pattern_tx #(.GAP(1), .MAXLEN(MAXLEN)) u_gap1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    pattern_tx #(.GAP(0), .MAXLEN(MAXLEN)) u_gap0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    function automatic logic [3:0] vec_of(input int which);
        if (which == 0) return {bus0.p1, bus0.p2, bus0.busy, bus0.done};
        return {bus1.p1, bus1.p2, bus1.busy, bus1.done};
    endfunction

    function automatic int qsize(input int which);
        return (which == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check_ev(input string tag, input ev_t e, input int c,
                            input logic [3:0] v, input int run);
        total++;
        if (e.cyc != c || v !== e.vec || (e.nbusy >= 0 && e.nbusy != run)) begin
            bad++;
            $display("FAIL %s event: got cyc=%0d {p1,p2,busy,done}=%b busy_run=%0d, want cyc=%0d %b busy_run=%0d",
                     tag, c, v, run, e.cyc, e.vec, e.nbusy);
        end
    endtask

    // Monitor for the GAP=0 instance.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus0.p1 || bus0.p2 || bus0.done) begin
                if (q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL gap0 unexpected pulse: got %b at cyc=%0d, want none", vec_of(0), cyc);
                end else begin
                    m0_e = q0.pop_front();
                    check_ev("gap0", m0_e, cyc, vec_of(0), run0);
                end
            end
            run0 = bus0.busy ? run0 + 1 : 0;
        end else begin
            run0 = 0;
        end
    end

    // Monitor for the GAP=1 instance.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus1.p1 || bus1.p2 || bus1.done) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL gap1 unexpected pulse: got %b at cyc=%0d, want none", vec_of(1), cyc);
                end else begin
                    m1_e = q1.pop_front();
                    check_ev("gap1", m1_e, cyc, vec_of(1), run1);
                end
            end
            run1 = bus1.busy ? run1 + 1 : 0;
        end else begin
            run1 = 0;
        end
    end

    task automatic push(input int which, input int c, input logic [3:0] v, input int nb);
        ev_t e;
        e.cyc   = c;
        e.vec   = v;
        e.nbusy = nb;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    // Expected events: symbol i at e0 + i*(1+gap), done after n*(1+gap).
    task automatic push_model(input int which, input logic [7:0] pat, input int l,
                              input int e0, input int gap, input int nmax, input bit with_done);
        int n;
        logic [7:0] p;
        p = pat;
        n = (l > int'(MAXLEN)) ? int'(MAXLEN) : l;
        for (int i = 0; i < n && i < nmax; i++) begin
            push(which, e0 + i * (1 + gap), p[n - 1 - i] ? V_P1 : V_P2, NB_ANY);
        end
        if (with_done) push(which, e0 + n * (1 + gap), V_DN, n * (1 + gap));
    endtask

    task automatic launch(input int which, input logic [7:0] pat, input logic [3:0] l, output int e);
        @(negedge clk);
        if (which == 0) begin
            bus0.start = 1'b1; bus0.pattern = pat; bus0.len = l;
        end else begin
            bus1.start = 1'b1; bus1.pattern = pat; bus1.len = l;
        end
        @(posedge clk);
        #1;
        e = cyc;
    endtask

    task automatic release_start(input int which);
        @(negedge clk);
        if (which == 0) bus0.start = 1'b0;
        else            bus1.start = 1'b0;
    endtask

    task automatic drain(input int which, input string tag);
        int n;
        n = 0;
        while (qsize(which) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        total++;
        if (qsize(which) != 0) begin
            bad++;
            $display("FAIL %s drain: got %0d pending events, want 0", tag, qsize(which));
            if (which == 0) q0.delete();
            else            q1.delete();
        end
    endtask

    task automatic idle_check(input int which, input string tag, input int ncyc);
        logic [3:0] v;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            v = vec_of(which);
            total++;
            if (v !== 4'b0000) begin
                bad++;
                $display("FAIL %s idle: got {p1,p2,busy,done}=%b at cyc=%0d, want 0000", tag, v, cyc);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        logic [3:0] v;

        reset = 1'b0;
        bus0.start = 1'b0; bus0.pattern = '0; bus0.len = '0; bus0.abort = 1'b0;
        bus1.start = 1'b0; bus1.pattern = '0; bus1.len = '0; bus1.abort = 1'b0;

        // reset state
        @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            v = vec_of(w);
            total++;
            if (v !== 4'b0000) begin
                bad++;
                $display("FAIL reset state dut%0d: got %b, want 0000", w, v);
            end
        end
        #17 reset = 1'b1;

        // GAP=1, 8'h0C len 4: p1 c1,c3  p2 c5,c7  done c9; start/pattern changes mid-transfer ignored
        launch(1, 8'h0C, 4'd4, e);
        push(1, e,     V_P1, NB_ANY);
        push(1, e + 2, V_P1, NB_ANY);
        push(1, e + 4, V_P2, NB_ANY);
        push(1, e + 6, V_P2, NB_ANY);
        push(1, e + 8, V_DN, 8);
        release_start(1);
        repeat (2) @(negedge clk);
        bus1.start = 1'b1; bus1.pattern = 8'hFF; bus1.len = 4'd1;
        @(negedge clk);
        bus1.start = 1'b0;
        drain(1, "gap1_0C");

        // GAP=0, 8'hA5 len 8: p1,p2,p1,p2,p2,p1,p2,p1 then done
        launch(0, 8'hA5, 4'd8, e);
        push(0, e,     V_P1, NB_ANY);
        push(0, e + 1, V_P2, NB_ANY);
        push(0, e + 2, V_P1, NB_ANY);
        push(0, e + 3, V_P2, NB_ANY);
        push(0, e + 4, V_P2, NB_ANY);
        push(0, e + 5, V_P1, NB_ANY);
        push(0, e + 6, V_P2, NB_ANY);
        push(0, e + 7, V_P1, NB_ANY);
        push(0, e + 8, V_DN, 8);
        release_start(0);
        drain(0, "gap0_A5");

        // len=0 ignored
        launch(1, 8'hFF, 4'd0, e);
        release_start(1);
        idle_check(1, "len0", 5);

        // len=12 clamps to 8 symbols
        launch(0, 8'h96, 4'd12, e);
        push_model(0, 8'h96, 12, e, 0, 99, 1'b1);
        release_start(0);
        drain(0, "gap0_len12");

        // abort in cycle 4 of the 8'h0C transfer
        launch(1, 8'h0C, 4'd4, e);
        push_model(1, 8'h0C, 4, e, 1, 2, 1'b0);
        release_start(1);
        repeat (3) @(negedge clk);
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        idle_check(1, "after_abort", 4);
        drain(1, "abort");

        // new start accepted after abort
        launch(1, 8'h05, 4'd3, e);
        push_model(1, 8'h05, 3, e, 1, 99, 1'b1);
        release_start(1);
        drain(1, "post_abort");

        // abort coincides with final gap expiry: no done
        launch(1, 8'h01, 4'd1, e);
        push_model(1, 8'h01, 1, e, 1, 99, 1'b0);
        release_start(1);
        @(negedge clk);
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        idle_check(1, "abort_vs_done", 4);
        drain(1, "abort_vs_done");

        // asynchronous reset mid-transfer
        launch(1, 8'hF0, 4'd4, e);
        push_model(1, 8'hF0, 4, e, 1, 1, 1'b0);
        release_start(1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        v = vec_of(1);
        total++;
        if (v !== 4'b0000) begin
            bad++;
            $display("FAIL async reset: got {p1,p2,busy,done}=%b, want 0000", v);
        end
        @(negedge clk);
        #3 reset = 1'b1;
        idle_check(1, "post_reset", 6);
        drain(1, "reset");

        launch(1, 8'h0C, 4'd4, e);
        push_model(1, 8'h0C, 4, e, 1, 99, 1'b1);
        release_start(1);
        drain(1, "post_reset_xfer");

        // start held high: back-to-back transfers, next p1 two cycles after done
        launch(1, 8'h03, 4'd2, e);
        for (int k = 0; k < 3; k++) push_model(1, 8'h03, 2, e + 6 * k, 1, 99, 1'b1);
        while (cyc < e + 16) @(negedge clk);
        bus1.start = 1'b0;
        drain(1, "held_start");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
